// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive path: default byte width, default
// receive FIFO depth and the pointer-width helper (index bits plus one wrap
// bit) used by the FIFO pointer logic.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_D_W   = 8;
    localparam int UART_DEPTH = 16;

    // Pointer width for a FIFO of the given depth: index bits plus wrap bit.
    function automatic int uart_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int UART_PTR_W = uart_ptr_w(UART_DEPTH);

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Storage array for the UART receive FIFO. One synchronous write port and
// one asynchronous (combinational) read port; the array has no reset.
//
// Ports
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : write data
//   i_raddr  : read index
//   o_rdata  : data at i_raddr, available in the same cycle
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int D_W   = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [D_W-1:0] i_wdata,
    input  logic [AW-1:0]  i_raddr,
    output logic [D_W-1:0] o_rdata
);

    logic [D_W-1:0] r_mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read gives the FIFO its zero-latency show-ahead head.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Show-ahead receive FIFO between a UART receiver and its consumer. Bytes
// arriving while the FIFO is full (and not being drained in the same cycle)
// are dropped and flagged through a sticky overrun bit.
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   wr_en       : one-cycle write strobe from the receiver
//   wr_data     : received byte
//   rd_data     : head entry, valid while rd_valid=1
//   rd_valid    : FIFO not empty
//   rd_ready    : consumer accepts head entry
//   level       : occupancy, 0..DEPTH
//   full        : level == DEPTH
//   almost_full : level >= AF_LVL
//   overrun     : sticky, set when a byte is dropped
//   clr_ovr     : synchronous clear of overrun (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int D_W    = UART_D_W,
    parameter int DEPTH  = UART_DEPTH,
    parameter int AF_LVL = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [D_W-1:0]         wr_data,
    output logic [D_W-1:0]         rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   almost_full,
    output logic                   overrun,
    input  logic                   clr_ovr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = uart_ptr_w(DEPTH);

    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] LVL_FULL  = PW'(DEPTH);
    localparam logic [PW-1:0] LVL_AFULL = PW'(AF_LVL);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_level;
    logic          r_full;
    logic          r_afull;
    logic          r_valid;
    logic          r_ovr;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovr_evt;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [PW-1:0] w_level_nxt;
    logic          w_ovr_nxt;

    // Pointer comparisons: equal means empty; same index with opposite wrap bit means full.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

    // Handshake decode; a pop frees a slot so a full FIFO can still take a byte that cycle.
    assign w_pop     = !w_empty && rd_ready;
    assign w_push    = wr_en && (!w_full || w_pop);
    assign w_ovr_evt = wr_en && w_full && !w_pop;

    // Next pointers, occupancy and overrun state.
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_ovr_nxt   = r_ovr;
        if (w_push) begin
            w_wptr_nxt = r_wptr + PTR_ONE;
        end else begin
            w_wptr_nxt = r_wptr;
        end
        if (w_pop) begin
            w_rptr_nxt = r_rptr + PTR_ONE;
        end else begin
            w_rptr_nxt = r_rptr;
        end
        // Modular difference of the wrap-extended pointers is the occupancy.
        w_level_nxt = w_wptr_nxt - w_rptr_nxt;
        if (w_ovr_evt) begin
            w_ovr_nxt = 1'b1;
        end else if (clr_ovr) begin
            w_ovr_nxt = 1'b0;
        end else begin
            w_ovr_nxt = r_ovr;
        end
    end

    // State and registered status flags, all derived from the next pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_level <= {PW{1'b0}};
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_afull <= (w_level_nxt >= LVL_AFULL);
            r_valid <= (w_level_nxt != {PW{1'b0}});
            r_ovr   <= w_ovr_nxt;
        end
    end

    uart_fifo_mem #(
        .D_W   (D_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (rd_data)
    );

    assign rd_valid    = r_valid;
    assign level       = r_level;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo: a queue-based model of the FIFO is
// compared against the DUT on every falling edge, plus directed scenarios
// with literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       full;
    logic       almost_full;
    logic       overrun;
    logic       clr_ovr;

    int n_pass  = 0;
    int n_total = 0;

    uart_rx_fifo #(
        .D_W    (8),
        .DEPTH  (DEPTH),
        .AF_LVL (AF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun),
        .clr_ovr     (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue of bytes plus a sticky overrun bit.
    logic [7:0] m_q[$];
    logic       m_ovr = 1'b0;
    bit         m_pop;
    bit         m_full;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_ovr <= 1'b0;
        end else begin
            m_pop  = (m_q.size() > 0) && rd_ready;
            m_full = (m_q.size() == DEPTH);
            if (m_pop) void'(m_q.pop_front());
            if (wr_en && (!m_full || m_pop)) m_q.push_back(wr_data);
            if (wr_en && m_full && !m_pop) m_ovr <= 1'b1;
            else if (clr_ovr)             m_ovr <= 1'b0;
        end
    end

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        chk("m_valid", rd_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("m_data", rd_data, m_q[0]);
        chk("m_level", level, m_q.size());
        chk("m_full", full, m_q.size() == DEPTH);
        chk("m_afull", almost_full, m_q.size() >= AF);
        chk("m_ovr", overrun, m_ovr);
    end

    task automatic step(input logic we, input logic [7:0] d, input logic rr, input logic co);
        wr_en   = we;
        wr_data = d;
        rd_ready = rr;
        clr_ovr = co;
        @(negedge clk);
    endtask

    int wp;

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Single byte into empty FIFO, visible next cycle.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("a5_valid", rd_valid, 1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_level", level, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("a5_pop_level", level, 0);

        // Fill to full, then one more byte is dropped.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_ovr", overrun, 0);
        chk("fill_level", level, 16);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("drop_full", full, 1);
        chk("drop_ovr", overrun, 1);
        chk("drop_level", level, 16);
        chk("drop_head", rd_data, 8'h00);

        // Write while full with a simultaneous pop.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("wp_level", level, 16);
        chk("wp_ovr", overrun, 1);
        chk("wp_head", rd_data, 8'h01);

        // Overrun clear and set/clear collision.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovr", overrun, 0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("setwin_ovr", overrun, 1);
        chk("setwin_level", level, 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr2_ovr", overrun, 0);

        // Drain: 0x01..0x0F then 0x55.
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", rd_data, 8'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_55", rd_data, 8'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", rd_valid, 0);

        // Interleaved pushes/pops across the wrap; almost_full edge at 12.
        for (int k = 0; k < 24; k++) begin
            step(1'b1, 8'(8'h80 + k), k[0], 1'b0);
            if (k == 21) begin
                chk("af_l11", level, 11);
                chk("af_off", almost_full, 0);
            end
            if (k == 22) begin
                chk("af_l12", level, 12);
                chk("af_on", almost_full, 1);
            end
        end
        for (int k = 0; k < 16; k++) begin
            step(!k[0], 8'(8'hC0 + k), 1'b1, 1'b0);
            if (k == 1) begin
                chk("af_dn_l11", level, 11);
                chk("af_dn_off", almost_full, 0);
            end
        end
        chk("il_level", level, 4);

        // Randomized traffic with varying write/read pressure.
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph == 0) ? 80 : (ph == 1) ? 50 : (ph == 2) ? 20 : 95;
            for (int c = 0; c < 500; c++) begin
                step($urandom_range(0, 99) < wp,
                     8'($urandom),
                     $urandom_range(0, 99) < (100 - wp + 10),
                     $urandom_range(0, 15) == 0);
            end
        end

        // Drain, load 7 entries, then reset mid-cycle.
        for (int c = 0; c < 40; c++) begin
            if (rd_valid) step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("pre7_empty", rd_valid, 0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        wr_en = 1'b0;
        chk("pre_rst_level", level, 7);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_afull", almost_full, 0);
        chk("mid_rst_ovr", overrun, 0);
        wr_en = 1'b1; wr_data = 8'h99; rd_ready = 1'b1; clr_ovr = 1'b1;
        @(negedge clk);
        chk("rst_ignore_level", level, 0);
        reset = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_valid", rd_valid, 1);
        chk("post_rst_data", rd_data, 8'h3C);
        chk("post_rst_level", level, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter D_W, default 8: data width in bits, matching the receiver byte width.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two, 4 or more.
REQ-003 SHALL have parameter AF_LVL, default 12: almost_full threshold, in the range 1 to DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port wr_en, input, 1 bit: one-cycle strobe from the receiver; wr_data is valid on this cycle.
REQ-007 SHALL have port wr_data, input, D_W bits: received byte.
REQ-008 SHALL have port rd_data, output, D_W bits: head entry; meaningful only while rd_valid=1.
REQ-009 SHALL have port rd_valid, output, 1 bit: FIFO holds at least one entry.
REQ-010 SHALL have port rd_ready, input, 1 bit: consumer accepts the head entry.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1 bits: current occupancy, 0 to DEPTH.
REQ-012 SHALL have port full, output, 1 bit: level==DEPTH.
REQ-013 SHALL have port almost_full, output, 1 bit: level>=AF_LVL.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag set when a byte is dropped.
REQ-015 SHALL have port clr_ovr, input, 1 bit: synchronous clear of overrun.

Function
REQ-016 SHALL be a show-ahead FIFO: rd_data presents the oldest entry whenever rd_valid=1, with no read latency.
REQ-017 SHALL pop exactly one entry on each cycle where rd_valid=1 and rd_ready=1; rd_ready SHALL be ignored while rd_valid=0.
REQ-018 SHALL accept a write when wr_en=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 SHALL make a byte written into an empty FIFO visible the next cycle (rd_valid=1, rd_data=byte): write-to-read latency 1.
REQ-020 SHALL leave level unchanged when a push and a pop occur in the same cycle; otherwise level SHALL change by +1 or -1.
REQ-021 SHALL use read and write pointers of clog2(DEPTH)+1 bits, with the MSB acting as a wrap bit.
REQ-022 SHALL declare full when the pointers have equal index and differing wrap bits, and empty when the pointers are equal; indices SHALL wrap from DEPTH-1 to 0.
REQ-023 SHALL, on wr_en=1 while full with no same-cycle pop, discard wr_data, leave the memory and pointers unchanged, and set overrun on the next edge.
REQ-024 SHALL hold overrun at 1 until a cycle with clr_ovr=1; if an overrun event and clr_ovr occur in the same cycle, set SHALL win.
REQ-025 SHALL register full, almost_full and level, or derive them purely from the pointers; they SHALL be consistent with the pointers on every cycle.
REQ-026 SHALL NOT change the stored data, the pointers or rd_data in any cycle with no accepted write and no pop.

Reset
REQ-027 SHALL, while reset=0, immediately force both pointers to 0, level=0, rd_valid=0, full=0, almost_full=0 and overrun=0.
REQ-028 SHALL discard all stored entries on reset, including a reset asserted mid-burst; the memory array need not be cleared.
REQ-029 SHALL ignore wr_en, rd_ready and clr_ovr while reset=0, and resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL take the D_W and DEPTH defaults from the shared package uart_pkg, which also holds the pointer-width helper constant.
REQ-031 SHALL place the storage array in one sub-module, uart_fifo_mem: synchronous write port, asynchronous read port, no reset.
REQ-032 SHALL keep the pointer, flag and overrun logic in uart_rx_fifo itself.

Verification
REQ-033 SHALL cover: write 0xA5 into an empty FIFO with rd_ready=0 -> next cycle rd_valid=1, rd_data=0xA5, level=1.
REQ-034 SHALL cover: write 16 bytes 0x00..0x0F, then a 17th byte 0xFF -> full=1, overrun=1, level=16, and the reads return 0x00..0x0F in order.
REQ-035 SHALL cover: while full, apply wr_en with 0x55 together with rd_valid and rd_ready -> 0x00 popped, 0x55 stored, level stays 16, overrun unchanged.
REQ-036 SHALL cover: 40 interleaved pushes and pops crossing the pointer wrap -> data order preserved, and almost_full toggles exactly at level 12.
REQ-037 SHALL cover: overrun event and clr_ovr in the same cycle -> overrun=1; clr_ovr alone on the next cycle -> overrun=0.
REQ-038 SHALL cover: assert reset at level=7 -> immediately level=0, rd_valid=0; the first write after release reads back correctly.
